// File: rtl/uart_rx_fabric.sv
// 8N1 UART receiver for the MSS UART transmit line: 2-flop synchronizer,
// mid-bit sampling FSM and a single-entry valid/ready output register.
module uart_rx_fabric #(
   parameter int CLKS_PER_BIT = 434
) (
   input  logic       CLK,
   input  logic       RESET,
   input  logic       MMUART_0_TXD,
   output logic [7:0] RX_DATA,
   output logic       RX_VALID,
   input  logic       RX_READY,
   output logic       FRAME_ERR,
   output logic       OVERRUN
);

   localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
   localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} state_t;

   state_t      state_q, state_d;
   logic [15:0] timer_q, timer_d;
   logic [2:0]  idx_q, idx_d;
   logic [7:0]  shift_q, shift_d;
   logic [7:0]  rx_data_q, rx_data_d;
   logic        rx_valid_q, rx_valid_d;
   logic        frame_err_q, frame_err_d;
   logic        overrun_q, overrun_d;
   logic        stop_ok;
   logic        rxd_p0, rxd_p1;
   logic        rxd_s;

   // synchronizer stage: idle-high so reset never looks like a start bit
   always_ff @(posedge CLK) begin
      if (RESET) begin
         rxd_p0 <= 1'b1;
         rxd_p1 <= 1'b1;
      end else begin
         rxd_p0 <= MMUART_0_TXD;
         rxd_p1 <= rxd_p0;
      end
   end

   assign rxd_s = rxd_p1;

   always_comb begin
      state_d     = state_q;
      timer_d     = timer_q;
      idx_d       = idx_q;
      shift_d     = shift_q;
      stop_ok     = 1'b0;
      frame_err_d = 1'b0;
      case (state_q)
         IDLE: begin
            if (!rxd_s) begin
               state_d = START;
               timer_d = 16'd0;
            end
         end
         START: begin
            if (timer_q == HALF_LAST) begin
               timer_d = 16'd0;
               idx_d   = 3'd0;
               state_d = rxd_s ? IDLE : DATA;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         DATA: begin
            if (timer_q == BIT_LAST) begin
               timer_d        = 16'd0;
               shift_d[idx_q] = rxd_s;
               if (idx_q == 3'd7) state_d = STOP;
               else               idx_d   = idx_q + 3'd1;
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         STOP: begin
            if (timer_q == BIT_LAST) begin
               timer_d = 16'd0;
               if (rxd_s) begin
                  stop_ok = 1'b1;
                  state_d = IDLE;
               end else begin
                  frame_err_d = 1'b1;
                  state_d     = BREAK;
               end
            end else begin
               timer_d = timer_q + 16'd1;
            end
         end
         BREAK: begin
            if (rxd_s) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // A transfer frees the register in the same cycle a new byte may land in it
   always_comb begin
      rx_data_d  = rx_data_q;
      rx_valid_d = rx_valid_q;
      overrun_d  = 1'b0;
      if (rx_valid_q && RX_READY) rx_valid_d = 1'b0;
      if (stop_ok) begin
         if (!rx_valid_q || RX_READY) begin
            rx_data_d  = shift_q;
            rx_valid_d = 1'b1;
         end else begin
            overrun_d = 1'b1;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state_q     <= IDLE;
         timer_q     <= 16'd0;
         idx_q       <= 3'd0;
         shift_q     <= 8'h00;
         rx_data_q   <= 8'h00;
         rx_valid_q  <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         timer_q     <= timer_d;
         idx_q       <= idx_d;
         shift_q     <= shift_d;
         rx_data_q   <= rx_data_d;
         rx_valid_q  <= rx_valid_d;
         frame_err_q <= frame_err_d;
         overrun_q   <= overrun_d;
      end
   end

   assign RX_DATA   = rx_data_q;
   assign RX_VALID  = rx_valid_q;
   assign FRAME_ERR = frame_err_q;
   assign OVERRUN   = overrun_q;

endmodule
